instr_fetch: RTL
================

# instr_fetch

Fetch stage sitting directly downstream of the program counter. Each cycle it takes the current `prog_ctr`, issues a read to the synchronous instruction memory, and tags the returned word with its address. It then buffers up to two fetched instructions for the decoder behind a valid/ready handshake. It discards wrong-path words on a branch redirect, holds the PC when its buffer is full, and stops fetching after delivering the HALT instruction.

## Interface
Parameters:
- `D`, 8, PC / instruction-address width (matches PC)
- `W`, 9, instruction word width
- `HALT_OP`, 9'h1FF, encoding of the halt instruction

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; same signal that drives PC `enable`
- `prog_ctr`  in  D  current PC value
- `redirect`  in  1  branch taken this cycle; asserted in the same cycle as PC `reljump_en`
- `imem_rd_en`  out  1  memory read strobe
- `imem_addr`  out  D  read address
- `imem_rdata`  in  W  read data, valid exactly one cycle after `imem_rd_en`
- `instr`  out  W  instruction to the decoder
- `instr_pc`  out  D  address of `instr`
- `instr_valid`  out  1  `instr`/`instr_pc` valid
- `instr_ready`  in  1  decoder accepts this cycle
- `pc_hold`  out  1  PC must not advance this cycle (drives the PC stall input)
- `done`  out  1  HALT delivered; fetch permanently stopped

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE when a word equal to `HALT_OP` is popped (`instr_valid & instr_ready`).
  - DONE holds until reset.
- `imem_addr` = `prog_ctr` combinationally at all times.
- Issue: in RUN, `imem_rd_en`=1 iff `occ + inflight − pop < 2`.
  - `occ` = FIFO count (0..2).
  - `inflight` = a read was issued last cycle and was not killed.
  - `pop` = `instr_valid & instr_ready`.
- `pc_hold` = RUN & !`imem_rd_en`. `pc_hold`=1 in DONE. `pc_hold`=0 in IDLE.
- Issue at cycle t records tag {addr}. At t+1, `imem_rdata` with its tag is pushed into the FIFO unless the read was killed.
- Redirect at cycle t:
  - kills the read issued at t (wrong path);
  - kills any read in flight from t−1;
  - flushes all FIFO entries except one being popped at t.
  - Issue at t+1 uses the redirected `prog_ctr`.
- HALT pop: all remaining FIFO entries and in-flight reads are discarded. `imem_rd_en`=0 from the next cycle onward.
- Push and pop of a full FIFO in the same cycle is legal; occupancy is unchanged.
- `start` outside IDLE is ignored.

## Timing
- Reset (async, `reset_n`=0) sets:
  - state=IDLE;
  - `imem_rd_en`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0;
  - `pc_hold`=0, `done`=0;
  - FIFO empty, no read in flight.
- Reset mid-operation drops all buffered and in-flight words immediately.
- Latency: `start` at cycle 0, RUN at cycle 1, first issue at cycle 1, push at end of cycle 2, `instr_valid`=1 at cycle 3. Issue-to-valid is 2 cycles.
- FIFO output is registered; no combinational path from `imem_rdata` to `instr`.
- `instr_valid` never deasserts without a pop, except on `redirect`, HALT pop or reset.
- `instr`/`instr_pc` are stable while `instr_valid & !instr_ready`.
- `done` rises the cycle after the HALT pop and stays high.

## Structure
- Package `fetch_pkg`: state enum `fetch_state_t` {IDLE, RUN, DONE}, `HALT_OP` default, FIFO depth constant 2.
- Sub-module `fetch_fifo`: 2-entry, {W+D}-bit, registered-output FIFO with flush, push, pop and count.
- Top-level `instr_fetch` holds the FSM, the in-flight/kill flag and the issue logic.

## Test plan
- Straight line:
  - Stimulus: ROM[0..3]=0x001..0x004, `instr_ready`=1, pulse `start`.
  - Required: `instr_valid` at cycle 3 with {0x001,pc 0}, then one word per cycle with pc 1, 2, 3.
- Backpressure:
  - Stimulus: hold `instr_ready`=0 after the first word.
  - Required: `pc_hold`=1 once occ+inflight=2; `instr`=0x001 stays stable.
  - Then release: words 0x002, 0x003 follow in order, with no loss or duplication.
- Redirect:
  - Stimulus: assert `redirect` for 1 cycle while FIFO holds 1 word and 1 read is in flight.
  - Required: both are discarded. The next `instr_valid` carries the word at the redirected `prog_ctr` 2 cycles later.
- Halt:
  - Stimulus: ROM[2]=`HALT_OP`.
  - Required: after HALT pop, `done`=1 the next cycle, `imem_rd_en`=0, `pc_hold`=1; ROM[3] is never presented.
- Async reset:
  - Stimulus: drop `reset_n` mid-stream with FIFO full.
  - Required: all outputs return to reset values without waiting for a clock edge. A new `start` restarts cleanly from `prog_ctr`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam logic [8:0]  HALT_OP_DEFAULT = 9'h1FF;
    localparam int unsigned FIFO_DEPTH      = 2;

    // A new read fits only if buffered plus in-flight words, minus the one leaving, stay below depth.
    function automatic logic can_issue(input logic [1:0] occ, input logic inflight, input logic pop);
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, inflight};
        return committed < (3'(FIFO_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer between the fetch stage and the decoder.
// The head entry is a register driven straight to the output; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [1:0]    count
);

    logic [DW-1:0] head_r;
    logic [DW-1:0] tail_r;
    logic [1:0]    count_r;
    logic          valid_r;
    logic [DW-1:0] head_s;
    logic [DW-1:0] tail_s;
    logic [1:0]    count_s;

    assign dout  = head_r;
    assign valid = valid_r;
    assign count = count_r;

    // Next entry contents and occupancy from flush/push/pop.
    always_comb begin
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        if (flush) begin
            count_s = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_s = din;
                    end else begin
                        tail_s = din;
                    end
                    count_s = count_r + 2'd1;
                end
                2'b01: begin
                    head_s  = tail_r;
                    count_s = count_r - 2'd1;
                end
                2'b11: begin
                    // Full: shift tail forward and refill; otherwise the new word replaces the head.
                    if (count_r == 2'(FIFO_DEPTH)) begin
                        head_s = tail_r;
                        tail_s = din;
                    end else begin
                        head_s = din;
                    end
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_s;
            tail_r  <= tail_s;
            count_r <= count_s;
            valid_r <= (count_s != 2'd0);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues reads at the current PC, tags returned words with their address
// and buffers them for the decoder, handling redirect, backpressure and HALT.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int           D       = 8,
    parameter int           W       = 9,
    parameter logic [W-1:0] HALT_OP = W'(HALT_OP_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [D-1:0] prog_ctr,
    input  logic         redirect,
    output logic         imem_rd_en,
    output logic [D-1:0] imem_addr,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] instr,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         pc_hold,
    output logic         done
);

    fetch_state_t   state_r;
    fetch_state_t   state_s;
    logic           inflight_r;
    logic           inflight_s;
    logic [D-1:0]   tag_r;
    logic           done_r;
    logic           run_s;
    logic           pop_s;
    logic           halt_pop_s;
    logic           rd_en_s;
    logic           flush_s;
    logic           push_s;
    logic [1:0]     occ_s;
    logic [W+D-1:0] fifo_dout_s;

    assign imem_addr  = prog_ctr;
    assign imem_rd_en = rd_en_s;
    assign done       = done_r;
    assign instr      = fifo_dout_s[W-1:0];
    assign instr_pc   = fifo_dout_s[W+D-1:W];

    // Issue, kill and buffer control; a redirect or HALT pop kills whatever is in flight.
    always_comb begin
        run_s      = (state_r == RUN);
        pop_s      = instr_valid & instr_ready;
        halt_pop_s = run_s & pop_s & (instr == HALT_OP);
        rd_en_s    = run_s & can_issue(occ_s, inflight_r, pop_s);
        flush_s    = (run_s & redirect) | halt_pop_s;
        push_s     = run_s & inflight_r & ~redirect & ~halt_pop_s;
        inflight_s = rd_en_s & ~redirect & ~halt_pop_s;
    end

    // Next state and PC stall.
    always_comb begin
        state_s = state_r;
        pc_hold = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
                pc_hold = 1'b0;
            end
            RUN: begin
                if (halt_pop_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
                pc_hold = ~rd_en_s;
            end
            DONE: begin
                state_s = DONE;
                pc_hold = 1'b1;
            end
            default: begin
                state_s = IDLE;
                pc_hold = 1'b0;
            end
        endcase
    end

    // State, in-flight flag and address tag of the outstanding read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            inflight_r <= 1'b0;
            tag_r      <= '0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= inflight_s;
            done_r     <= (state_s == DONE);
            if (rd_en_s) begin
                tag_r <= prog_ctr;
            end else begin
                tag_r <= tag_r;
            end
        end
    end

    fetch_fifo #(
        .DW (W + D)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush_s),
        .push    (push_s),
        .din     ({tag_r, imem_rdata}),
        .pop     (pop_s),
        .dout    (fifo_dout_s),
        .valid   (instr_valid),
        .count   (occ_s)
    );

endmodule
